// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequence generator.
package gray_pkg;

    localparam int GRAY_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gseq_state_t;

    // Reference binary-to-Gray conversion at the default word width.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_encoder.sv
// Combinational binary-to-Gray encoder: each output bit is the xor of adjacent input bits.
module gray_encoder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
);

    assign o = i ^ (i >> 1);

endmodule

// File: rtl/gray_sequence_gen.sv
// Walks a binary counter from first_bin to last_bin (up or down, modular) and
// streams each value Gray-encoded over a valid/ready handshake.
module gray_sequence_gen
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] first_bin,
    input  logic [WIDTH-1:0] last_bin,
    output logic [WIDTH-1:0] m_gray,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    gseq_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             dir_q, dir_d;
    logic             valid_q, valid_d;
    logic             mlast_q, mlast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH-1:0] enc_in_s;
    logic [WIDTH-1:0] gray_next_s;
    logic             xfer_s;

    assign xfer_s     = valid_q & m_ready;
    assign cnt_next_s = dir_q ? (cnt_q + WIDTH'(1'b1)) : (cnt_q - WIDTH'(1'b1));
    // In IDLE the "next count" is the programmed first value, so one encoder serves both.
    assign enc_in_s   = (state_q == IDLE) ? first_bin : cnt_next_s;

    gray_encoder #(.WIDTH(WIDTH)) u_enc (
        .i (enc_in_s),
        .o (gray_next_s)
    );

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gray_d  = gray_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        mlast_d = mlast_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    last_d  = last_bin;
                    cnt_d   = first_bin;
                    gray_d  = gray_next_s;
                    valid_d = 1'b1;
                    mlast_d = (first_bin == last_bin);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (xfer_s) begin
                    if (mlast_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        mlast_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_next_s;
                        gray_d  = gray_next_s;
                        mlast_d = (cnt_next_s == last_q);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                mlast_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            gray_q  <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            mlast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gray_q  <= gray_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            mlast_q <= mlast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign m_gray  = gray_q;
    assign m_valid = valid_q;
    assign m_last  = mlast_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_gray_sequence_gen.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops and checks on each transfer.
module tb_gray_sequence_gen;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] first_bin = '0;
    logic [W-1:0] last_bin = '0;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_gray;
    logic         m_valid;
    logic         m_last;
    logic         busy;
    logic         done;

    gray_sequence_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .dir       (dir),
        .first_bin (first_bin),
        .last_bin  (last_bin),
        .m_gray    (m_gray),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] gray;
        logic [W-1:0] bin;
        logic         last;
        logic         first;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Downstream decoder model: binary bit i is the xor of all Gray bits at or above i.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Ready driver: 0 random, 1 always high, 2 toggling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = ~m_ready;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [W-1:0] prev_gray;
        logic [W-1:0] stall_gray;
        logic         have_prev;
        logic         stalled;
        exp_t         e;
        have_prev = 1'b0;
        stalled   = 1'b0;
        prev_gray = '0;
        stall_gray = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                have_prev = 1'b0;
                stalled   = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", W'(m_valid), W'(1));
                    chk("hold_gray", m_gray, stall_gray);
                end
                stalled    = m_valid && !m_ready;
                stall_gray = m_gray;
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%h expected=none", m_gray);
                    end else begin
                        e = q.pop_front();
                        chk("gray_word", m_gray, e.gray);
                        chk("m_last", W'(m_last), W'(e.last));
                        chk("decoded", gray2bin(m_gray), e.bin);
                        if (have_prev && !e.first)
                            chk("one_bit_step", W'($countones(prev_gray ^ m_gray)), W'(1));
                        prev_gray = m_gray;
                        have_prev = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gray"}, m_gray, '0);
        chk({tag, "_valid"}, W'(m_valid), '0);
        chk({tag, "_last"}, W'(m_last), '0);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
    endtask

    task automatic push_expected(input logic [W-1:0] f, input logic [W-1:0] l, input logic d);
        logic [W-1:0] len;
        logic [W-1:0] b;
        exp_t         e;
        len = (d ? (l - f) : (f - l));
        for (longint k = 0; k <= longint'(len); k++) begin
            b       = d ? (f + W'(k)) : (f - W'(k));
            e.bin   = b;
            e.gray  = b ^ (b >> 1);
            e.last  = (k == longint'(len));
            e.first = (k == 0);
            q.push_back(e);
        end
    endtask

    task automatic run_seq(input logic [W-1:0] f, input logic [W-1:0] l, input logic d, input bit poke);
        int  len;
        bit  done_seen;
        int  cyc;
        @(posedge clk);
        #1;
        first_bin = f;
        last_bin  = l;
        dir       = d;
        start     = 1'b1;
        push_expected(f, l, d);
        len = q.size();
        @(posedge clk);
        #1;
        start     = 1'b0;
        first_bin = $urandom;
        last_bin  = $urandom;
        dir       = 1'($urandom_range(0, 1));
        done_seen = 1'b0;
        cyc       = 0;
        while (cyc < 4000 && !done_seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_valid", W'(m_valid), W'(1));
                chk("first_gray", m_gray, f ^ (f >> 1));
            end
            if (poke && cyc == 1) begin
                start     = 1'b1;
                first_bin = $urandom;
                last_bin  = $urandom;
            end
            if (cyc == 2) start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                chk("queue_empty_at_done", W'(q.size()), '0);
                chk("valid_in_done", W'(m_valid), '0);
                if (ready_mode == 1) chk("done_cycle", W'(cyc), W'(len + 1));
                if (poke) start = 1'b1;
            end else begin
                chk("busy_run", W'(busy), W'(1));
            end
        end
        chk("done_seen", W'(done_seen), W'(1));
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", W'(busy), '0);
        chk("idle_done", W'(done), '0);
        chk("idle_valid", W'(m_valid), '0);
    endtask

    task automatic reset_mid_sequence();
        int cyc;
        ready_mode = 1;
        @(posedge clk);
        #1;
        first_bin = 32'd100;
        last_bin  = 32'd109;
        dir       = 1'b1;
        start     = 1'b1;
        push_expected(32'd100, 32'd109, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (q.size() > 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_word3", W'(q.size()), W'(7));
        #2;
        nrst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        q.delete();
        repeat (2) @(negedge clk);
        #2;
        nrst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset2");
    endtask

    initial begin
        logic [W-1:0] f;
        logic [W-1:0] l;
        logic         d;
        int           len;
        int           sel;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        ready_mode = 1;
        run_seq(32'd0, 32'd3, 1'b1, 1'b0);
        ready_mode = 2;
        run_seq(32'd5, 32'd7, 1'b1, 1'b0);
        ready_mode = 1;
        run_seq(32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0);
        run_seq(32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_seq(32'd9, 32'd9, 1'b1, 1'b1);
        run_seq(32'd20, 32'd14, 1'b0, 1'b1);

        reset_mid_sequence();

        for (int r = 0; r < 1000; r++) begin
            ready_mode = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       f = 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
                1:       f = W'($urandom_range(0, 15));
                default: f = $urandom;
            endcase
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 16);
            l   = d ? (f + W'(len - 1)) : (f - W'(len - 1));
            run_seq(f, l, d, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_sequence_gen.md
# gray_sequence_gen

Sequential Gray-code source that sits directly upstream of the 32-bit Gray decoder. On a start pulse it walks a binary counter from a programmed first value to a programmed last value, up or down, with modular wrap. It emits each value Gray-encoded over a valid/ready handshake. The decoder consumes these words; decoded output must reproduce the binary count sequence exactly.

## Interface
- `WIDTH`, default 32: word width; must match the downstream decoder width.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to begin a sequence; honoured only in IDLE.
- `dir` input 1: 1 = count up, 0 = count down; sampled with `start`.
- `first_bin` input WIDTH: binary value of the first emitted word; sampled with `start`.
- `last_bin` input WIDTH: binary value of the final emitted word; sampled with `start`.
- `m_gray` output WIDTH: current word, Gray-encoded (`b ^ (b >> 1)`); registered.
- `m_valid` output 1: `m_gray` holds a word to transfer.
- `m_ready` input 1: downstream accepts; a transfer occurs when `m_valid && m_ready`.
- `m_last` output 1: the current word is the final one of the sequence.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse after the final word is transferred.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `m_valid = 0`.
  - On `start`, capture `dir` and `last_bin`, load `cnt <= first_bin`, load `m_gray <= gray(first_bin)`, then go to RUN.
- RUN:
  - `m_valid = 1`.
  - `m_last = (cnt == last_q)`, where `last_q` is the `last_bin` value captured on `start`.
  - On transfer with `m_last` set: go to DONE.
  - On transfer otherwise: `cnt <= cnt ± 1` modulo 2^WIDTH, and `m_gray <= gray(next cnt)`.
  - With no transfer: `m_gray`, `m_valid` and `m_last` hold stable. Valid must never drop before its word is accepted.
- DONE:
  - `done = 1` and `m_valid = 0` for exactly one cycle, then go to IDLE.
- `start` in RUN or DONE is ignored; it is neither queued nor able to restart the sequence.
- Sequence length:
  - Up: `((last - first) mod 2^WIDTH) + 1` words.
  - Down: `((first - last) mod 2^WIDTH) + 1` words.
  - `first == last` gives exactly one word.
- Wrap-around is allowed in both directions: up passes `2^WIDTH-1 → 0`, down passes `0 → 2^WIDTH-1`.
- Consecutive transferred words differ in exactly one bit, including across a wrap.
- Inputs `dir`, `first_bin` and `last_bin` are don't-care outside the `start` cycle.

## Timing
- Reset values: state IDLE, `cnt = 0`, `last_q = 0`, `m_gray = 0`, `m_valid = 0`, `m_last = 0`, `busy = 0`, `done = 0`.
- Reset asserted mid-sequence: everything returns immediately to reset values, and the in-flight word is dropped.
- `start` sampled at edge t: `m_valid = 1` with `gray(first_bin)` from cycle t+1.
- Throughput is one word per cycle while `m_ready` is held high.
- Transfer of the last word at edge t: DONE with `done = 1` in cycle t+1; IDLE in cycle t+2, where a new `start` is accepted.
- `m_valid`, `m_gray`, `m_last`, `busy` and `done` all come straight from flops; there is no combinational path from `m_ready` or `start` to any output.

## Structure
- Shared package `gray_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} gseq_state_t`.
  - function `bin2gray`.
  - localparam `GRAY_W = 32`.
- Sub-module `gray_encoder #(WIDTH)`: purely combinational `o = i ^ (i >> 1)`, instantiated once on the next-count path.
- Top level holds the FSM, the `cnt` and `last_q` registers, and the output registers.

## Test plan
- Reset and idle: after `nrst` release, all outputs are 0.
  - `start` with `first = 0`, `last = 3`, `dir = 1`, `m_ready = 1`.
  - Expect `m_gray = 0, 1, 3, 2` on cycles 1–4, `m_last` on the 4th word, `done` on cycle 5, `busy` low on cycle 6.
- Backpressure:
  - `first = 5`, `last = 7`, up, with `m_ready` toggling 0/1 each cycle.
  - Expect `m_gray = 7, 5, 4` in order, each held stable across its stalled cycles; no word lost or duplicated.
- Wrap and down count:
  - Up run with `first = 32'hFFFF_FFFE`, `last = 1` gives four words: `32'h8000_0001`, `32'h8000_0000`, `0`, `1`.
  - Down run with `first = 1`, `last = 32'hFFFF_FFFF` gives `1`, `0`, `32'h8000_0000`.
- Single word and ignored start:
  - `first = last = 9` gives one word `13` with `m_last = 1`.
  - `start` pulsed during RUN and during DONE has no effect.
- Reset mid-sequence and end-to-end:
  - Drop `nrst` during word 3 of a 10-word run; all outputs return to 0 asynchronously.
  - Then chain the generator into the decoder for 1000 random up/down runs with random `m_ready`.
  - Expect decoded words equal the expected binary sequence, and every consecutive pair of Gray words differs in exactly one bit.
